// File: rtl/syzygy_dac_init.sv
// Sole controller of the DAC pod SPI engine: after a startup delay it writes and read-verifies
// the init table, then serves single host register reads/writes.
module syzygy_dac_init #(
  parameter int unsigned            INIT_LEN       = 4,
  parameter logic [14*INIT_LEN-1:0] INIT_TABLE     = {14'h0700, 14'h0300, 14'h0200, 14'h0100},
  parameter int unsigned            STARTUP_CYCLES = 1000,
  parameter int unsigned            MAX_RETRIES    = 2,
  parameter int unsigned            TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] spi_reg,
  output logic [7:0] spi_data_in,
  output logic       spi_rw,
  output logic       spi_send,
  input  logic       spi_done,
  input  logic [7:0] spi_data_out,
  input  logic       host_req,
  input  logic       host_rw,
  input  logic [5:0] host_reg,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_timeout,
  output logic       init_done,
  output logic       init_error,
  output logic [3:0] err_index
);
  // state     | meaning
  // STARTUP   | power-up delay before the first transfer
  // ISSUE_W   | launch write of the current table entry
  // WAIT_W    | wait for that write to complete
  // ISSUE_R   | launch readback of the same register
  // WAIT_R    | wait for the readback, capture data
  // CHECK     | compare readback, retry / flag / advance
  // READY     | init finished, accept host requests
  // HOST_WAIT | host transfer in flight
  // ACK_GAP   | one idle cycle after host_ack
  typedef enum logic [3:0] {
    ST_STARTUP, ST_ISSUE_W, ST_WAIT_W, ST_ISSUE_R, ST_WAIT_R,
    ST_CHECK, ST_READY, ST_HOST_WAIT, ST_ACK_GAP
  } state_t;

  localparam int unsigned SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [SW-1:0] START_LOAD = SW'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMR_LOAD   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [3:0]    LAST_IDX   = 4'(INIT_LEN - 1);

  state_t        state_q;
  logic [SW-1:0] start_q;
  logic [TW-1:0] tmr_q;
  logic          seen_low_q;
  logic [3:0]    idx_q;
  logic [RW-1:0] retry_q;
  logic [7:0]    rd_q;
  logic [5:0]    spi_reg_q;
  logic [7:0]    spi_data_q;
  logic          spi_rw_q;
  logic          spi_send_q;
  logic          host_ack_q;
  logic [7:0]    host_rdata_q;
  logic          host_timeout_q;
  logic          init_done_q;
  logic          init_error_q;
  logic [3:0]    err_index_q;

  logic [13:0] entry;
  logic        last_entry;
  logic        in_wait;
  logic        xfer_done;
  logic        xfer_to;

  assign entry      = 14'(INIT_TABLE >> (14 * idx_q));
  assign last_entry = (idx_q == LAST_IDX);
  assign in_wait    = (state_q == ST_WAIT_W) || (state_q == ST_WAIT_R) || (state_q == ST_HOST_WAIT);
  // Completion needs the engine to have dropped spi_done first, otherwise the
  // still-idle level right after the send would look like a finished transfer.
  assign xfer_done  = seen_low_q & spi_done;
  assign xfer_to    = ~xfer_done & (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_STARTUP;
      start_q        <= START_LOAD;
      tmr_q          <= '0;
      seen_low_q     <= 1'b0;
      idx_q          <= '0;
      retry_q        <= '0;
      rd_q           <= '0;
      spi_reg_q      <= '0;
      spi_data_q     <= '0;
      spi_rw_q       <= 1'b0;
      spi_send_q     <= 1'b0;
      host_ack_q     <= 1'b0;
      host_rdata_q   <= '0;
      host_timeout_q <= 1'b0;
      init_done_q    <= 1'b0;
      init_error_q   <= 1'b0;
      err_index_q    <= '0;
    end else begin
      spi_send_q     <= 1'b0;
      host_ack_q     <= 1'b0;
      host_timeout_q <= 1'b0;
      if (in_wait) begin
        if (!spi_done) seen_low_q <= 1'b1;
        if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
      end
      case (state_q)
        ST_STARTUP: begin
          if (start_q == '0) state_q <= ST_ISSUE_W;
          else start_q <= start_q - 1'b1;
        end
        ST_ISSUE_W: begin
          if (spi_done) begin
            spi_reg_q  <= entry[13:8];
            spi_data_q <= entry[7:0];
            spi_rw_q   <= 1'b0;
            spi_send_q <= 1'b1;
            tmr_q      <= TMR_LOAD;
            seen_low_q <= 1'b0;
            state_q    <= ST_WAIT_W;
          end
        end
        ST_WAIT_W, ST_WAIT_R: begin
          if (xfer_done) begin
            if (state_q == ST_WAIT_R) begin
              rd_q    <= spi_data_out;
              state_q <= ST_CHECK;
            end else begin
              state_q <= ST_ISSUE_R;
            end
          end else if (xfer_to) begin
            if (!init_error_q) begin
              init_error_q <= 1'b1;
              err_index_q  <= idx_q;
            end
            init_done_q <= 1'b1;
            state_q     <= ST_READY;
          end
        end
        ST_ISSUE_R: begin
          if (spi_done) begin
            spi_data_q <= '0;
            spi_rw_q   <= 1'b1;
            spi_send_q <= 1'b1;
            tmr_q      <= TMR_LOAD;
            seen_low_q <= 1'b0;
            state_q    <= ST_WAIT_R;
          end
        end
        ST_CHECK: begin
          if (rd_q != entry[7:0] && retry_q < RETRY_MAX) begin
            retry_q <= retry_q + 1'b1;
            state_q <= ST_ISSUE_W;
          end else begin
            // A permanently failing entry is flagged but the rest of the table still runs.
            if (rd_q != entry[7:0] && !init_error_q) begin
              init_error_q <= 1'b1;
              err_index_q  <= idx_q;
            end
            retry_q <= '0;
            if (last_entry) begin
              init_done_q <= 1'b1;
              state_q     <= ST_READY;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_ISSUE_W;
            end
          end
        end
        ST_READY: begin
          if (host_req && spi_done) begin
            spi_reg_q  <= host_reg;
            spi_data_q <= host_wdata;
            spi_rw_q   <= host_rw;
            spi_send_q <= 1'b1;
            tmr_q      <= TMR_LOAD;
            seen_low_q <= 1'b0;
            state_q    <= ST_HOST_WAIT;
          end
        end
        ST_HOST_WAIT: begin
          if (xfer_done) begin
            host_ack_q <= 1'b1;
            if (spi_rw_q) host_rdata_q <= spi_data_out;
            state_q <= ST_ACK_GAP;
          end else if (xfer_to) begin
            host_ack_q     <= 1'b1;
            host_timeout_q <= 1'b1;
            state_q        <= ST_ACK_GAP;
          end
        end
        ST_ACK_GAP: state_q <= ST_READY;
        default:    state_q <= ST_STARTUP;
      endcase
    end
  end

  assign spi_reg      = spi_reg_q;
  assign spi_data_in  = spi_data_q;
  assign spi_rw       = spi_rw_q;
  assign spi_send     = spi_send_q;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;
  assign host_timeout = host_timeout_q;
  assign init_done    = init_done_q;
  assign init_error   = init_error_q;
  assign err_index    = err_index_q;

endmodule

// File: tb/tb_syzygy_dac_init.sv
// Bench for syzygy_dac_init: behavioural SPI engine with injectable readback faults,
// and a table-walk reference model that predicts the transfer sequence and error flags.
module tb_syzygy_dac_init;
  localparam int STARTUP = 1000;
  localparam int TIMEOUT = 10000;
  localparam int MAXR    = 2;
  localparam int LEN     = 4;
  localparam logic [55:0] TABLE = {14'h0700, 14'h0300, 14'h0200, 14'h0100};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] spi_reg;
  logic [7:0] spi_data_in;
  logic       spi_rw, spi_send;
  logic       spi_done = 1'b1;
  logic [7:0] spi_data_out = 8'h00;
  logic       host_req = 1'b0, host_rw = 1'b0;
  logic [5:0] host_reg = '0;
  logic [7:0] host_wdata = '0;
  logic       host_ack, host_timeout, init_done, init_error;
  logic [7:0] host_rdata;
  logic [3:0] err_index;

  syzygy_dac_init #(.INIT_LEN(LEN), .INIT_TABLE(TABLE), .STARTUP_CYCLES(STARTUP),
                    .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .spi_reg(spi_reg), .spi_data_in(spi_data_in), .spi_rw(spi_rw),
    .spi_send(spi_send), .spi_done(spi_done), .spi_data_out(spi_data_out),
    .host_req(host_req), .host_rw(host_rw), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_timeout(host_timeout),
    .init_done(init_done), .init_error(init_error), .err_index(err_index));

  always #4 clk = ~clk;

  typedef struct { bit rw; bit [5:0] rg; bit [7:0] d; int t; } txn_t;

  int   checks = 0, failures = 0;
  int   cyc = 0, rel_cyc = 0, viol = 0;
  txn_t log_q[$];
  txn_t exp_q[$];
  bit [7:0] mem [64];
  bit [7:0] ref_regs [64];
  int   bad_n [64];
  bit [7:0] bad_v [64];
  int   rd_cnt [64];
  bit   hang_next = 0;
  bit   exp_err;
  int   exp_eidx;
  bit [7:0] exp_rdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: random busy time, echoes writes, optional corrupted reads or a hang.
  logic busy = 1'b0, prev_send = 1'b0, l_rw;
  logic [5:0] l_reg;
  logic [7:0] l_d;
  int unsigned bcnt;
  always @(posedge clk) begin
    if (reset) begin
      spi_done <= 1'b1; busy <= 1'b0; prev_send <= 1'b0;
    end else begin
      prev_send <= spi_send;
      if (spi_send && (!spi_done || prev_send)) viol++;
      if (busy && (spi_reg !== l_reg || spi_rw !== l_rw || spi_data_in !== l_d)) viol++;
      if (spi_send && !busy) begin
        log_q.push_back('{spi_rw, spi_reg, spi_data_in, cyc});
        if (hang_next) hang_next = 0;
        else begin
          busy <= 1'b1; spi_done <= 1'b0; bcnt <= $urandom_range(6, 1);
          l_reg <= spi_reg; l_rw <= spi_rw; l_d <= spi_data_in;
        end
      end else if (busy) begin
        if (bcnt == 0) begin
          if (!l_rw) mem[l_reg] = l_d;
          else if (rd_cnt[l_reg] < bad_n[l_reg]) begin
            spi_data_out <= bad_v[l_reg]; rd_cnt[l_reg]++;
          end else spi_data_out <= mem[l_reg];
          spi_done <= 1'b1; busy <= 1'b0;
        end else bcnt <= bcnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pk(input txn_t x);
    return {x.rw, x.rg, x.d};
  endfunction

  // Walk the table the way the sequence is defined: write, read, retry while corrupted.
  task automatic build_ref();
    int seen [64];
    logic [13:0] ent;
    bit ok;
    exp_q.delete(); exp_err = 0; exp_eidx = 0;
    foreach (seen[i]) seen[i] = 0;
    for (int e = 0; e < LEN; e++) begin
      ent = TABLE[14*e +: 14];
      ok = 0;
      for (int a = 0; a <= MAXR && !ok; a++) begin
        exp_q.push_back('{1'b0, ent[13:8], ent[7:0], 0});
        exp_q.push_back('{1'b1, ent[13:8], 8'h00, 0});
        ok = (seen[ent[13:8]] >= bad_n[ent[13:8]]) || (bad_v[ent[13:8]] == ent[7:0]);
        seen[ent[13:8]]++;
      end
      ref_regs[ent[13:8]] = ent[7:0];
      if (!ok && !exp_err) begin exp_err = 1; exp_eidx = e; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete(); viol = 0; hang_next = 0; exp_rdata = 8'h00;
    foreach (mem[i]) begin
      mem[i] = 0; bad_n[i] = 0; bad_v[i] = 0; rd_cnt[i] = 0; ref_regs[i] = 0;
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < STARTUP + 2000) begin @(negedge clk); n++; end
    chk({tag, "_init_done"}, init_done, 1);
  endtask

  task automatic chk_startup(input string tag);
    chk({tag, "_startup_gap"}, (log_q.size() > 0) && (log_q[0].t - rel_cyc >= STARTUP) &&
        (log_q[0].t - rel_cyc <= STARTUP + 5), 1);
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_ntxn"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_txn%0d", tag, i), pk(log_q[i]), pk(exp_q[i]));
    chk({tag, "_init_error"}, init_error, exp_err);
    chk({tag, "_err_index"}, err_index, exp_eidx);
    chk({tag, "_bus_rules"}, viol, 0);
    chk_startup(tag);
  endtask

  function automatic int count_writes(input bit [5:0] rg);
    int c = 0;
    foreach (log_q[i]) if (!log_q[i].rw && log_q[i].rg == rg) c++;
    return c;
  endfunction

  task automatic host_xact(input bit rw, input bit [5:0] rg, input bit [7:0] wd,
                           input bit exp_to, input int budget, input string tag);
    int n, acks, n0;
    n0 = log_q.size(); n = 0; acks = 0;
    host_rw = rw; host_reg = rg; host_wdata = wd; host_req = 1'b1;
    @(negedge clk);
    while (host_ack !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_ack"}, host_ack, 1);
    chk({tag, "_timeout"}, host_timeout, exp_to);
    if (rw && !exp_to) exp_rdata = ref_regs[rg];
    if (!rw && !exp_to) ref_regs[rg] = wd;
    chk({tag, "_rdata"}, host_rdata, exp_rdata);
    host_req = 1'b0;
    repeat (8) begin @(negedge clk); if (host_ack) acks++; end
    chk({tag, "_extra_acks"}, acks, 0);
    chk({tag, "_nsend"}, log_q.size() - n0, 1);
    if (log_q.size() > n0) chk({tag, "_txn"}, pk(log_q[n0]), {rw, rg, wd});
  endtask

  initial begin
    int n, acks, n0;
    bit [5:0] rg;
    bit [7:0] wd;

    // Clean init, reset values, host traffic
    do_reset();
    chk("rst_init_done", init_done, 0);
    chk("rst_init_error", init_error, 0);
    chk("rst_err_index", err_index, 0);
    chk("rst_spi_send", spi_send, 0);
    chk("rst_spi_bus", {spi_rw, spi_reg, spi_data_in}, 0);
    chk("rst_host_ack", {host_ack, host_timeout}, 0);
    chk("rst_host_rdata", host_rdata, 0);
    mem[6'h1F] = 8'hA5; ref_regs[6'h1F] = 8'hA5;
    build_ref();
    release_reset();
    wait_init("clean");
    check_init("clean");
    host_xact(1'b1, 6'h1F, 8'h00, 1'b0, 200, "host_rd1f");
    n0 = log_q.size(); acks = 0; n = 0;
    host_rw = 1'b1; host_reg = 6'h1F; host_wdata = 8'h00; host_req = 1'b1;
    while (acks < 3 && n < 300) begin
      @(negedge clk); n++;
      if (host_ack) begin acks++; if (acks == 3) host_req = 1'b0; end
    end
    host_req = 1'b0;
    repeat (20) begin @(negedge clk); if (host_ack) acks++; end
    chk("hold_acks", acks, 3);
    chk("hold_sends", log_q.size() - n0, 3);
    chk("hold_rdata", host_rdata, 8'hA5);
    for (int k = 0; k < 6; k++) begin
      rg = 6'($urandom_range(8, 63)); wd = 8'($urandom);
      host_xact(1'b0, rg, wd, 1'b0, 200, $sformatf("rnd_wr%0d", k));
      host_xact(1'b1, rg, 8'($urandom), 1'b0, 200, $sformatf("rnd_rd%0d", k));
    end

    // Two corrupted reads on reg 0x02 recover on the third attempt
    do_reset();
    bad_n[2] = 2; bad_v[2] = 8'hFF;
    build_ref();
    release_reset();
    wait_init("retry");
    check_init("retry");
    chk("retry_reg2_writes", count_writes(6'h02), 3);
    chk("retry_no_error", init_error, 0);

    // Reg 0x03 never reads back: error on entry 2, sequence continues
    do_reset();
    bad_n[3] = 1000; bad_v[3] = 8'h55;
    build_ref();
    release_reset();
    wait_init("stuck");
    check_init("stuck");
    chk("stuck_reg3_writes", count_writes(6'h03), 3);
    chk("stuck_err", {init_done, init_error, err_index}, {1'b1, 1'b1, 4'd2});
    chk("stuck_last_reg7", (log_q.size() > 0) ? log_q[log_q.size()-1].rg : 6'h3F, 6'h07);

    // Engine ignores the first send: init times out, then a host timeout
    do_reset();
    hang_next = 1;
    release_reset();
    n = 0;
    while (log_q.size() == 0 && n < STARTUP + 50) begin @(negedge clk); n++; end
    chk_startup("hang");
    n = 0;
    while (init_done !== 1'b1 && n < TIMEOUT + 100) begin @(negedge clk); n++; end
    chk("hang_timeout_cycles", (n >= TIMEOUT - 3) && (n <= TIMEOUT + 3), 1);
    chk("hang_err", {init_done, init_error, err_index}, {1'b1, 1'b1, 4'd0});
    chk("hang_ntxn", log_q.size(), 1);
    hang_next = 1;
    host_xact(1'b1, 6'h1F, 8'h00, 1'b1, TIMEOUT + 100, "host_to");

    // Host request pending from reset release, reset pulsed while in WAIT_W
    do_reset();
    mem[6'h2A] = 8'h3C;
    host_rw = 1'b1; host_reg = 6'h2A; host_wdata = 8'h11; host_req = 1'b1;
    release_reset();
    n = 0;
    while (log_q.size() == 0 && n < STARTUP + 50) begin @(negedge clk); n++; end
    chk_startup("rst1");
    chk("rst1_first_write", (log_q.size() > 0) ? pk(log_q[0]) : 15'h7FFF, {1'b0, 6'h01, 8'h00});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_send_low", spi_send, 0);
    @(negedge clk);
    log_q.delete(); viol = 0;
    bad_n[6'h2A] = 0;
    build_ref();
    ref_regs[6'h2A] = 8'h3C;
    release_reset();
    wait_init("rst2");
    check_init("rst2");
    n = 0;
    while (host_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("rst2_host_ack", host_ack, 1);
    chk("rst2_host_rdata", host_rdata, 8'h3C);
    chk("rst2_host_txn", (log_q.size() > exp_q.size()) ? pk(log_q[exp_q.size()]) : 15'h7FFF,
        {1'b1, 6'h2A, 8'h11});
    host_req = 1'b0;
    repeat (5) @(negedge clk);

    // Randomised readback faults against the reference walk
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int e = 0; e < LEN; e++) begin
        int c;
        logic [13:0] ent;
        ent = TABLE[14*e +: 14];
        c = $urandom_range(0, 4);
        bad_n[ent[13:8]] = (c == 4) ? 1000 : c;
        bad_v[ent[13:8]] = ent[7:0] ^ 8'($urandom_range(1, 255));
      end
      build_ref();
      release_reset();
      wait_init($sformatf("rand%0d", r));
      check_init($sformatf("rand%0d", r));
      chk($sformatf("rand%0d_done", r), init_done, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
